// File: rtl/color_rand.sv
// color_rand: pseudo-random colour generator for the colour-bounce game.
// A free-running 16-bit Galois LFSR (taps 16'hB400) produces, every clock,
// four distinct non-black platform colours and a ball colour that matches
// one of them. Both outputs are registered one cycle behind the LFSR state.
// Optional build macro: COLOR_RAND_NO_REPEAT_EN -- when defined, the ball
// colour never repeats on consecutive cycles.
module color_rand (
  input  logic        clk,
  input  logic        resetn,
  output logic [11:0] new_color_plats,
  output logic [2:0]  new_color_ball
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [11:0] PLATS_RST = 12'b001010100111;
  localparam logic [2:0]  BALL_RST  = 3'b111;

  // Step size in 1..6 derived from a 3-bit field (field mod 6, plus one).
  function automatic logic [2:0] step_size(input logic [2:0] field);
    logic [2:0] m;
    m = (field >= 3'd6) ? (field - 3'd6) : field;
    return m + 3'd1;
  endfunction

  // Advance a colour 1..7 by s positions around the mod-7 ring, skipping 0.
  // Worst case (c-1)+s = 6+6 = 12 fits comfortably in 4 bits.
  function automatic logic [2:0] step_color(input logic [2:0] c, input logic [2:0] s);
    logic [3:0] t;
    t = {1'b0, c} - 4'd1 + {1'b0, s};
    if (t >= 4'd7) t = t - 4'd7;
    return t[2:0] + 3'd1;
  endfunction

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [2:0]  cand [4];
  logic [2:0]  step;
  logic [1:0]  ball_idx;
  logic [2:0]  ball_cand;
  logic [2:0]  ball_next;

  // Candidate colours and next LFSR state, all from the current LFSR state.
  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    cand[0]   = (lfsr[2:0] == 3'd0) ? 3'd7 : lfsr[2:0];
    step      = step_size(lfsr[5:3]);
    cand[1]   = step_color(cand[0], step);
    cand[2]   = step_color(cand[1], step);
    cand[3]   = step_color(cand[2], step);
    ball_idx  = lfsr[7:6];
    ball_cand = cand[ball_idx];
`ifdef COLOR_RAND_NO_REPEAT_EN
    // Bump to the next platform colour (wrapping) when the pick would repeat;
    // the four candidates are distinct, so the bumped colour always differs.
    ball_next = (ball_cand == new_color_ball) ? cand[ball_idx + 2'd1] : ball_cand;
`else
    ball_next = ball_cand;
`endif
  end

  // LFSR and output registers; reset returns the whole block to its seed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr            <= LFSR_SEED;
      new_color_plats <= PLATS_RST;
      new_color_ball  <= BALL_RST;
    end else begin
      lfsr            <= lfsr_next;
      new_color_plats <= {cand[3], cand[2], cand[1], cand[0]};
      new_color_ball  <= ball_next;
    end
  end

endmodule

// File: tb/tb_color_rand.sv
// tb_color_rand: directed-vector bench for color_rand, plus long-run
// invariant, period and reset-corner sequences.
module tb_color_rand;

  logic        clk;
  logic        resetn;
  logic [11:0] new_color_plats;
  logic [2:0]  new_color_ball;

  int n_checks = 0;
  int n_pass   = 0;

  color_rand dut (
    .clk             (clk),
    .resetn          (resetn),
    .new_color_plats (new_color_plats),
    .new_color_ball  (new_color_ball)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [11:0] plats;
    logic [2:0]  ball;
  } vec_t;

  vec_t tbl [5];

  localparam logic [11:0] PLATS_RST = 12'b001010100111;
  localparam logic [2:0]  BALL_RST  = 3'b111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [2:0] m_step(input logic [2:0] c, input int s);
    int t;
    t = ((int'(c) - 1 + s) % 7) + 1;
    return t[2:0];
  endfunction

  // Hard bound on the whole run.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] mr;
    logic [2:0]  mc [4];
    int          ms, mi;
    logic [2:0]  prev_ball, exp_ball;
    logic [11:0] p;
    logic [2:0]  b;
    logic [2:0]  f [4];
    logic [14:0] key;
    logic [14:0] win  [16];
    logic [14:0] hist [16];
    int inv_bad, model_bad, ball_bad, rep_bad, forced, match_at;
    bit same;

    // cycle index after reset release, expected plats, expected ball
    tbl[0] = '{1, 12'b010100110001, 3'b010};
    tbl[1] = '{2, 12'b011010001111, 3'b001};
    tbl[2] = '{3, 12'b110100010111, 3'b111};
    tbl[3] = '{4, 12'b010101001100, 3'b101};
    tbl[4] = '{5, 12'b101011001110, 3'b001};

    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_plats", 32'(new_color_plats), 32'(PLATS_RST));
    check("rst_ball",  32'(new_color_ball),  32'(BALL_RST));

    // Directed vectors from reset release.
    @(negedge clk) resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("vec%0d_plats", tbl[k].cyc), 32'(new_color_plats), 32'(tbl[k].plats));
      check($sformatf("vec%0d_ball",  tbl[k].cyc), 32'(new_color_ball),  32'(tbl[k].ball));
    end

    // Mid-run asynchronous reset: takes effect with no clock edge.
    repeat (7) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("async_rst_plats", 32'(new_color_plats), 32'(PLATS_RST));
    check("async_rst_ball",  32'(new_color_ball),  32'(BALL_RST));
    @(posedge clk); #1;
    check("hold_rst_plats", 32'(new_color_plats), 32'(PLATS_RST));
    @(negedge clk) resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("rerun%0d_plats", k), 32'(new_color_plats), 32'(tbl[k].plats));
      check($sformatf("rerun%0d_ball",  k), 32'(new_color_ball),  32'(tbl[k].ball));
    end

    // Reset pulse shorter than a clock period, entirely between edges.
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1 resetn = 1'b0;
    #2 resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("short%0d_plats", k), 32'(new_color_plats), 32'(tbl[k].plats));
      check($sformatf("short%0d_ball",  k), 32'(new_color_ball),  32'(tbl[k].ball));
    end

    // Long run: invariants, reference comparison, period.
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;
    mr = 16'hACE1;
    prev_ball = BALL_RST;
    inv_bad = 0; model_bad = 0; ball_bad = 0; rep_bad = 0; forced = 0; match_at = 0;
    for (int i = 0; i < 16; i++) begin
      win[i] = '0;
      hist[i] = '0;
    end
    for (int n = 1; n <= 70000; n++) begin
      mc[0] = (mr[2:0] == 3'd0) ? 3'd7 : mr[2:0];
      ms = (int'(mr[5:3]) % 6) + 1;
      for (int k = 1; k < 4; k++) mc[k] = m_step(mc[k-1], ms);
      mi = int'(mr[7:6]);

      @(posedge clk); #1;
      p = new_color_plats;
      b = new_color_ball;
      for (int k = 0; k < 4; k++) f[k] = p[3*k +: 3];
      for (int k = 0; k < 4; k++) begin
        if (f[k] == 3'd0) inv_bad++;
        for (int j = k + 1; j < 4; j++) if (f[k] == f[j]) inv_bad++;
      end
      if (b != f[0] && b != f[1] && b != f[2] && b != f[3]) inv_bad++;
      if (p != {mc[3], mc[2], mc[1], mc[0]}) model_bad++;
`ifdef COLOR_RAND_NO_REPEAT_EN
      if (b == prev_ball) rep_bad++;
      if (mc[mi] == prev_ball) begin
        forced++;
        exp_ball = mc[(mi + 1) % 4];
      end else begin
        exp_ball = mc[mi];
      end
      if (b != exp_ball) ball_bad++;
      key = {p, 3'b000};
`else
      if (b != mc[mi]) ball_bad++;
      key = {p, b};
`endif
      if (n <= 16) win[n-1] = key;
      for (int k = 0; k < 15; k++) hist[k] = hist[k+1];
      hist[15] = key;
      if (n > 16 && match_at == 0) begin
        same = 1'b1;
        for (int k = 0; k < 16; k++) if (hist[k] != win[k]) same = 1'b0;
        if (same) match_at = n - 15;
      end
      prev_ball = b;
      mr = {1'b0, mr[15:1]} ^ (mr[0] ? 16'hB400 : 16'h0000);
    end
    check("invariant_bad_cycles", 32'(inv_bad),   32'd0);
    check("plats_model_bad",      32'(model_bad), 32'd0);
    check("ball_model_bad",       32'(ball_bad),  32'd0);
    check("period_restart_cycle", 32'(match_at),  32'd65536);
`ifdef COLOR_RAND_NO_REPEAT_EN
    check("ball_repeat_cycles", 32'(rep_bad), 32'd0);
    check("forced_repeat_seen", 32'(forced > 0), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
